// File: rtl/phy_mem_arbiter_pkg.sv
// Shared arbiter definitions: state encodings, the default starvation limit and the counter width.
// No logic, so no latency or backpressure.
package phy_mem_arbiter_pkg;

    typedef enum logic {
        ARB_CPU = 1'b0,
        ARB_DMA = 1'b1
    } arb_state_t;

    localparam int STARVE_LIMIT_DEF = 4;
    localparam int WAIT_CNT_W       = 4;

endpackage

// File: rtl/phy_mem_arbiter_starve_cnt.sv
// Saturating DMA wait counter; reached is high while the count equals LIMIT.
// Latency: reached updates one cycle after inc/clr. Backpressure: inc is ignored once saturated; clr wins over inc.
module arb_starve_cnt
    import phy_mem_arbiter_pkg::*;
#(
    parameter int LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic reached
);

    localparam logic [WAIT_CNT_W-1:0] LIM = WAIT_CNT_W'(LIMIT);

    logic [WAIT_CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (clr) begin
            wait_cnt <= '0;
        end else if (inc && (wait_cnt != LIM)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign reached = (wait_cnt == LIM);

endmodule

// File: rtl/phy_mem_arbiter.sv
// Two-master physical memory arbiter: the CPU owns memory by default, and DMA is granted after STARVE_LIMIT waiting cycles.
// Latency: the CPU path is combinational. A DMA access holds memory for one cycle plus any downstream stall, and dma_ack follows on the next cycle.
// Backpressure: mem_busy stalls both masters. A DMA grant waits for a CPU write to finish.
module phy_mem_arbiter
    import phy_mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_is_write,
    output logic [31:0] cpu_rdata,
    output logic        cpu_busy,
    input  logic        dma_req,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic        dma_is_write,
    output logic [31:0] dma_rdata,
    output logic        dma_ack,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_is_write,
    input  logic [31:0] mem_rdata,
    input  logic        mem_busy
);

    arb_state_t state;
    logic       reached;
    logic       grant;
    logic       dma_done;
    logic       cnt_inc;
    logic       cnt_clr;

    // A CPU write is never preempted. A deferred grant keeps the saturated count.
    assign grant    = (state == ARB_CPU) && dma_req && reached && !cpu_is_write && !mem_busy;
    assign dma_done = (state == ARB_DMA) && !mem_busy;
    assign cnt_inc  = (state == ARB_CPU) && dma_req;
    assign cnt_clr  = ((state == ARB_CPU) && !dma_req) || dma_done;

    arb_starve_cnt #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc     (cnt_inc),
        .clr     (cnt_clr),
        .reached (reached)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ARB_CPU;
            dma_ack   <= 1'b0;
            dma_rdata <= '0;
        end else begin
            dma_ack <= 1'b0;
            case (state)
                ARB_CPU: begin
                    if (grant) state <= ARB_DMA;
                end
                ARB_DMA: begin
                    if (dma_done) begin
                        if (!dma_is_write) dma_rdata <= mem_rdata;
                        dma_ack <= 1'b1;
                        state   <= ARB_CPU;
                    end
                end
                default: state <= ARB_CPU;
            endcase
        end
    end

    always_comb begin
        mem_addr     = cpu_addr;
        mem_wdata    = cpu_wdata;
        mem_is_write = cpu_is_write;
        cpu_busy     = mem_busy;
        if (state == ARB_DMA) begin
            mem_addr     = dma_addr;
            mem_wdata    = dma_wdata;
            mem_is_write = dma_is_write;
            cpu_busy     = 1'b1;
        end
    end

    assign cpu_rdata = mem_rdata;

endmodule

// File: tb/tb_phy_mem_arbiter.sv
// Scoreboard bench for phy_mem_arbiter: stimulus queues expected DMA acks (cycle and data), and a negedge monitor retires them.
// A second instance with STARVE_LIMIT = 0 shares the inputs and checks the immediate-grant case.
module tb_phy_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;
    logic        cpu_is_write, dma_req, dma_is_write, mem_busy;
    logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
    logic        cpu_busy, dma_ack, mem_is_write;
    logic [31:0] z_cpu_rdata, z_dma_rdata, z_mem_addr, z_mem_wdata;
    logic        z_cpu_busy, z_dma_ack, z_mem_is_write;

    always #5 clk = ~clk;

    phy_mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_is_write(cpu_is_write),
        .cpu_rdata(cpu_rdata), .cpu_busy(cpu_busy),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_is_write(dma_is_write),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_is_write(mem_is_write),
        .mem_rdata(mem_rdata), .mem_busy(mem_busy)
    );

    phy_mem_arbiter #(.STARVE_LIMIT(0)) dut0 (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_is_write(cpu_is_write),
        .cpu_rdata(z_cpu_rdata), .cpu_busy(z_cpu_busy),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_is_write(dma_is_write),
        .dma_rdata(z_dma_rdata), .dma_ack(z_dma_ack),
        .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata), .mem_is_write(z_mem_is_write),
        .mem_rdata(mem_rdata), .mem_busy(mem_busy)
    );

    typedef struct {
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;
    int   c;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_ack(input logic [31:0] rdata, input int at_cyc);
        exp_t e;
        e.rdata = rdata;
        e.cyc   = at_cyc;
        sb.push_back(e);
    endtask

    // Monitor: every ack retires one scoreboard entry.
    always @(negedge clk) begin
        if (dma_ack) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", {31'b0, dma_ack}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ack_cycle", cyc, e.cyc);
                chk("ack_rdata", dma_rdata, e.rdata);
            end
        end
    end

    initial begin
        rst = 1'b1;
        cpu_addr = '0; cpu_wdata = '0; cpu_is_write = 1'b0;
        dma_req = 1'b0; dma_addr = '0; dma_wdata = '0; dma_is_write = 1'b0;
        mem_rdata = '0; mem_busy = 1'b0;
        step(2);
        chk("reset_ack", {31'b0, dma_ack}, 32'd0);
        chk("reset_rdata", dma_rdata, 32'd0);
        chk("reset_busy", {31'b0, cpu_busy}, 32'd0);
        rst = 1'b0;

        // Idle DMA: the CPU passes straight through.
        cpu_addr = 32'h0000_0100; cpu_wdata = 32'hDEAD_0001; mem_rdata = 32'h1234_5678;
        step(3);
        chk("idle_addr", mem_addr, 32'h0000_0100);
        chk("idle_wdata", mem_wdata, 32'hDEAD_0001);
        chk("idle_rdata", cpu_rdata, 32'h1234_5678);
        chk("idle_busy", {31'b0, cpu_busy}, 32'd0);
        cpu_is_write = 1'b1; mem_busy = 1'b1; #1;
        chk("idle_is_write", {31'b0, mem_is_write}, 32'd1);
        chk("idle_busy_follow", {31'b0, cpu_busy}, 32'd1);
        cpu_is_write = 1'b0; mem_busy = 1'b0;
        step(1);

        // DMA read with STARVE_LIMIT = 4.
        dma_addr = 32'h0020_0000; mem_rdata = 32'hCAFE_BABE; dma_req = 1'b1;
        c = cyc; push_ack(32'hCAFE_BABE, c + 6);
        for (int i = 1; i <= 4; i++) begin
            step(1);
            chk("read_wait_busy", {31'b0, cpu_busy}, 32'd0);
            chk("read_wait_addr", mem_addr, 32'h0000_0100);
        end
        step(1);
        chk("read_grant_busy", {31'b0, cpu_busy}, 32'd1);
        chk("read_grant_addr", mem_addr, 32'h0020_0000);
        chk("read_grant_cpu_rdata", cpu_rdata, 32'hCAFE_BABE);
        step(1);
        chk("read_release_busy", {31'b0, cpu_busy}, 32'd0);
        dma_req = 1'b0;
        step(2);

        // Grant deferral behind CPU writes.
        dma_addr = 32'h0020_0040; mem_rdata = 32'h0BAD_F00D; dma_req = 1'b1;
        c = cyc; push_ack(32'h0BAD_F00D, c + 9);
        step(4);
        cpu_is_write = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("defer_busy", {31'b0, cpu_busy}, 32'd0);
            chk("defer_is_write", {31'b0, mem_is_write}, 32'd1);
        end
        cpu_is_write = 1'b0;
        step(1);
        chk("defer_grant_busy", {31'b0, cpu_busy}, 32'd1);
        chk("defer_grant_is_write", {31'b0, mem_is_write}, 32'd0);
        step(1);
        dma_req = 1'b0;
        step(2);

        // Downstream stall while in DMA.
        dma_addr = 32'h0020_0080; mem_rdata = 32'h55AA_33CC; dma_req = 1'b1;
        c = cyc; push_ack(32'h55AA_33CC, c + 11);
        step(5);
        chk("stall_grant_busy", {31'b0, cpu_busy}, 32'd1);
        mem_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("stall_busy", {31'b0, cpu_busy}, 32'd1);
            chk("stall_addr", mem_addr, 32'h0020_0080);
            chk("stall_is_write", {31'b0, mem_is_write}, 32'd0);
        end
        mem_busy = 1'b0;
        step(1);
        dma_req = 1'b0;
        step(2);

        // Reset in the middle of a DMA access.
        dma_addr = 32'h0020_00C0; mem_rdata = 32'h1111_2222; dma_req = 1'b1;
        step(5);
        chk("rst_pre_busy", {31'b0, cpu_busy}, 32'd1);
        rst = 1'b1; #1;
        chk("rst_busy", {31'b0, cpu_busy}, 32'd0);
        chk("rst_ack", {31'b0, dma_ack}, 32'd0);
        chk("rst_rdata", dma_rdata, 32'd0);
        rst = 1'b0;
        c = cyc; push_ack(32'h1111_2222, c + 6);
        step(4);
        chk("rst_rewait_busy", {31'b0, cpu_busy}, 32'd0);
        step(1);
        chk("rst_regrant_busy", {31'b0, cpu_busy}, 32'd1);
        step(1);
        dma_req = 1'b0;
        step(2);

        // Back-to-back: a read, then a write, with dma_req held high.
        dma_addr = 32'h0000_0300; mem_rdata = 32'h600D_CAFE; dma_req = 1'b1;
        c = cyc; push_ack(32'h600D_CAFE, c + 6); push_ack(32'h600D_CAFE, c + 12);
        step(6);
        dma_is_write = 1'b1; dma_wdata = 32'hA5A5_A5A5; dma_addr = 32'h0000_0304;
        mem_rdata = 32'hDEAD_BEEF;
        step(4);
        chk("b2b_wait_busy", {31'b0, cpu_busy}, 32'd0);
        chk("b2b_wait_is_write", {31'b0, mem_is_write}, 32'd0);
        step(1);
        chk("b2b_wr_busy", {31'b0, cpu_busy}, 32'd1);
        chk("b2b_wr_is_write", {31'b0, mem_is_write}, 32'd1);
        chk("b2b_wr_wdata", mem_wdata, 32'hA5A5_A5A5);
        chk("b2b_wr_addr", mem_addr, 32'h0000_0304);
        step(1);
        chk("b2b_after_is_write", {31'b0, mem_is_write}, 32'd0);
        chk("b2b_rdata_kept", dma_rdata, 32'h600D_CAFE);
        dma_req = 1'b0; dma_is_write = 1'b0;
        step(2);

        // STARVE_LIMIT = 0 grants on the first edge; the main instance grants as usual.
        dma_addr = 32'h0000_0400; dma_wdata = 32'h0000_0077; mem_rdata = 32'h0F0F_0F0F; dma_req = 1'b1;
        c = cyc; push_ack(32'h0F0F_0F0F, c + 6);
        step(1);
        chk("lim0_grant_busy", {31'b0, z_cpu_busy}, 32'd1);
        chk("lim0_grant_addr", z_mem_addr, 32'h0000_0400);
        chk("lim0_grant_wdata", z_mem_wdata, 32'h0000_0077);
        chk("lim0_grant_is_write", {31'b0, z_mem_is_write}, 32'd0);
        step(1);
        chk("lim0_ack", {31'b0, z_dma_ack}, 32'd1);
        chk("lim0_rdata", z_dma_rdata, 32'h0F0F_0F0F);
        chk("lim0_release_busy", {31'b0, z_cpu_busy}, 32'd0);
        chk("lim0_cpu_rdata", z_cpu_rdata, 32'h0F0F_0F0F);
        step(4);
        dma_req = 1'b0;
        step(3);

        chk("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
